// File: rtl/adjust_pulse_gen.sv
// adjust_pulse_gen: turns raw up/down buttons into one-cycle step pulses.
// Each button is synchronized and then debounced. The FSM below gives one
// pulse per press and an optional auto-repeat while the button is held.
// Build option: define ADJUST_PULSE_AUTOREPEAT_EN to build HOLD/REPEAT
// auto-repeat. Without it, each press gives exactly one pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no button accepted; wait for exactly one debounced press
// PRESS   | emit the first pulse in the latched direction
// HOLD    | button still held; wait HOLD_CYCLES from the first pulse
// REPEAT  | button still held; one pulse every REPEAT_CYCLES
// LOCKOUT | disabled or both pressed; wait for both released + enable
module adjust_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 32,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_up,
  input  logic i_btn_down,
  input  logic i_enable,
  output logic o_up,
  output logic o_down
);

  // Reject out-of-range parameters while the design is elaborated.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255 ||
      HOLD_CYCLES < 2 || HOLD_CYCLES > 65535 ||
      REPEAT_CYCLES < 2 || REPEAT_CYCLES > 65535) begin : g_bad_params
    $error("adjust_pulse_gen: parameter out of range");
  end

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

`ifdef ADJUST_PULSE_AUTOREPEAT_EN
  typedef enum logic [2:0] {IDLE, PRESS, HOLD, REPEAT, LOCKOUT} state_t;
  localparam logic [15:0] HOLD_LOAD   = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] REPEAT_LOAD = 16'(REPEAT_CYCLES - 1);
  logic [15:0] cnt, cnt_nxt;
`else
  typedef enum logic [2:0] {IDLE, PRESS, LOCKOUT} state_t;
`endif

  // Bit 0 is the up button and bit 1 is the down button.
  logic [1:0] meta, btn_sync, btn_deb;
  logic [7:0] db_cnt [2];
  state_t     state, state_nxt;
  logic       dir;       // 0 = up, 1 = down
  logic       load_dir, pulse, held;

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta     <= '0;
      btn_sync <= '0;
    end else begin
      meta     <= {i_btn_down, i_btn_up};
      btn_sync <= meta;
    end
  end

  // Debounce: the level flips only after DEBOUNCE_CYCLES disagreeing cycles in a row.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_deb <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_sync[i] != btn_deb[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            btn_deb[i] <= btn_sync[i];
            db_cnt[i]  <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign held = dir ? btn_deb[1] : btn_deb[0];

  // Next-state and pulse decode. A disable or a double press overrides everything.
  always_comb begin
    state_nxt = state;
    load_dir  = 1'b0;
    pulse     = 1'b0;
`ifdef ADJUST_PULSE_AUTOREPEAT_EN
    cnt_nxt   = cnt;
`endif
    if (!i_enable || (&btn_deb)) begin
      state_nxt = LOCKOUT;
    end else begin
      case (state)
        IDLE: begin
          if (btn_deb[0] ^ btn_deb[1]) begin
            state_nxt = PRESS;
            load_dir  = 1'b1;
          end
        end
        PRESS: begin
          if (!held) begin
            state_nxt = IDLE;
          end else begin
            pulse = 1'b1;
`ifdef ADJUST_PULSE_AUTOREPEAT_EN
            state_nxt = HOLD;
            cnt_nxt   = HOLD_LOAD;
`else
            state_nxt = LOCKOUT;
`endif
          end
        end
`ifdef ADJUST_PULSE_AUTOREPEAT_EN
        HOLD, REPEAT: begin
          if (!held) begin
            state_nxt = IDLE;
          end else if (cnt == '0) begin
            pulse     = 1'b1;
            state_nxt = REPEAT;
            cnt_nxt   = REPEAT_LOAD;
          end else begin
            cnt_nxt = cnt - 16'd1;
          end
        end
`endif
        LOCKOUT: begin
          if (btn_deb == 2'b00) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, direction, interval counter and registered step outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      dir    <= 1'b0;
      o_up   <= 1'b0;
      o_down <= 1'b0;
`ifdef ADJUST_PULSE_AUTOREPEAT_EN
      cnt    <= '0;
`endif
    end else begin
      state  <= state_nxt;
      if (load_dir) dir <= btn_deb[1];
      o_up   <= pulse & ~dir;
      o_down <= pulse & dir;
`ifdef ADJUST_PULSE_AUTOREPEAT_EN
      cnt    <= cnt_nxt;
`endif
    end
  end

endmodule

// File: doc/adjust_pulse_gen.md
ADJUST_PULSE_GEN -- requirements
Module: adjust_pulse_gen

Interface
REQ-001 The block SHALL expose parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to accept a button level change (range 2..255).
REQ-002 The block SHALL expose parameter HOLD_CYCLES, default 32, cycles from the first pulse to the first auto-repeat pulse (range 2..65535).
REQ-003 The block SHALL expose parameter REPEAT_CYCLES, default 8, cycles between auto-repeat pulses (range 2..65535).
REQ-004 The block SHALL have port i_clk  input  1  sole clock; all logic on the rising edge.
REQ-005 The block SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port i_btn_up  input  1  raw asynchronous "up" button level, high = pressed.
REQ-007 The block SHALL have port i_btn_down  input  1  raw asynchronous "down" button level, high = pressed.
REQ-008 The block SHALL have port i_enable  input  1  synchronous adjust enable; low suppresses all pulses.
REQ-009 The block SHALL have port o_up  output  1  registered single-cycle step pulse, drives the hour counter's i_up.
REQ-010 The block SHALL have port o_down  output  1  registered single-cycle step pulse, drives the hour counter's i_down.

Function
REQ-011 Each raw button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each synchronized button SHALL have a debounced level that changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any shorter disagreement restarts the count; press and release are handled identically.
REQ-013 The FSM SHALL have states IDLE, PRESS, HOLD, REPEAT, LOCKOUT, with a direction register (UP/DOWN) latched on leaving IDLE.
REQ-014 IDLE -> PRESS when exactly one debounced button is high and i_enable is high; the direction is latched from that button.
REQ-015 In PRESS the block SHALL assert the latched-direction output for exactly one cycle, then move to HOLD.
REQ-016 HOLD SHALL count HOLD_CYCLES cycles from the first pulse, then emit one pulse and enter REPEAT; REPEAT SHALL emit one pulse every REPEAT_CYCLES cycles.
REQ-017 Latency: raw press first sampled high at edge N with no bounce -> first pulse high in the cycle starting at edge N+DEBOUNCE_CYCLES+3.
REQ-018 Debounced release of the latched button in PRESS/HOLD/REPEAT SHALL return to IDLE with no further pulse; a pulse due in that same cycle is dropped.
REQ-019 Both debounced buttons high simultaneously, in any state, SHALL move to LOCKOUT; no pulse is emitted in that cycle.
REQ-020 i_enable low in any state SHALL move to LOCKOUT and suppress outputs the same cycle.
REQ-021 LOCKOUT SHALL return to IDLE only when both debounced buttons are low and i_enable is high; a button still held never resumes pulsing.
REQ-022 o_up and o_down SHALL never be high in the same cycle, and each pulse SHALL last exactly one cycle.
REQ-023 Interval counters SHALL saturate-free reload on every state entry; no wrap produces a spurious pulse.

Reset
REQ-024 i_rst high at a rising edge SHALL clear synchronizers, debounced levels (0), counters and direction, set state IDLE, and drive o_up=o_down=0 in the following cycle.
REQ-025 Reset asserted mid-operation SHALL abort any pending pulse; a button held through reset is treated as a new press (full debounce latency) after release of i_rst.

Configuration
REQ-026 Macro ADJUST_PULSE_AUTOREPEAT_EN defined: behaviour as REQ-013..REQ-023.
REQ-027 Macro ADJUST_PULSE_AUTOREPEAT_EN undefined: HOLD and REPEAT states and their counters SHALL not be built; PRESS goes to LOCKOUT after its pulse, giving exactly one pulse per press; HOLD_CYCLES and REPEAT_CYCLES are ignored.

Verification (defaults, macro defined unless stated)
REQ-028 i_rst high 2 cycles with buttons toggling -> o_up=o_down=0 throughout and one cycle after; state IDLE.
REQ-029 i_btn_up high 3 cycles, then low -> no pulse on either output.
REQ-030 i_btn_up held clean from edge N -> o_up pulses at N+7, N+39, N+47, N+55 ...; release -> no pulse later than 7 cycles after the release edge.
REQ-031 i_btn_up and i_btn_down pressed same cycle, held 100 cycles -> zero pulses; release both, press down -> o_down at press+7.
REQ-032 i_enable dropped during REPEAT with up held -> no pulse from that cycle; i_enable restored while held -> none until release and new press.
REQ-033 Macro undefined, i_btn_down held 200 cycles -> exactly one o_down pulse, at press+7.
